// File: rtl/lsu_mem_if_if.sv
// Data-bus bundle between the load/store unit and memory.
// The LSU is the master (req/we/addr/be/wdata out, gnt/rvalid/rdata in).
interface lsu_mem_if_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    o_bus_req;
    logic                    o_bus_we;
    logic [DATA_WIDTH-1:0]   o_bus_addr;
    logic [DATA_WIDTH/8-1:0] o_bus_be;
    logic [DATA_WIDTH-1:0]   o_bus_wdata;
    logic                    i_bus_gnt;
    logic                    i_bus_rvalid;
    logic [DATA_WIDTH-1:0]   i_bus_rdata;

    modport master (
        output o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata,
        input  i_bus_gnt, i_bus_rvalid, i_bus_rdata
    );

    modport slave (
        input  o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata,
        output i_bus_gnt, i_bus_rvalid, i_bus_rdata
    );
endinterface

// File: rtl/lsu_mem_if.sv
// MEM-stage load/store unit: lane-aligns stores, extends loads,
// and stalls the pipe while a req/gnt/rvalid bus access is open.
module lsu_mem_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_M,
    input  logic                  i_we_M,
    input  logic [2:0]            i_funct3_M,
    input  logic [DATA_WIDTH-1:0] i_addr_M,
    input  logic [DATA_WIDTH-1:0] i_wdata_M,
    output logic [DATA_WIDTH-1:0] o_read_data_M,
    output logic                  o_stall_M,
    output logic                  o_misaligned_M,
    output logic                  o_bus_err,
    lsu_mem_if_if.master          bus
);
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            off_q, off_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  mis_q, mis_d;
    logic                  err_q, err_d;

    logic                  legal;
    logic [3:0]            be_n;
    logic [DATA_WIDTH-1:0] wdata_n;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] ext;
    logic                  stall;
    logic                  tmo;
    logic                  req;

    // Legality, byte-lane mask and replicated store data of the MEM request
    always_comb begin
        legal   = 1'b0;
        be_n    = 4'b1111;
        wdata_n = i_wdata_M;
        unique case (i_funct3_M)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~i_addr_M[0];
            3'b010:  legal = (i_addr_M[1:0] == 2'b00);
            3'b100:  legal = ~i_we_M;
            3'b101:  legal = ~i_we_M & ~i_addr_M[0];
            default: legal = 1'b0;
        endcase
        unique case (i_funct3_M[1:0])
            2'b00: begin
                be_n    = 4'b0001 << i_addr_M[1:0];
                wdata_n = {4{i_wdata_M[7:0]}};
            end
            2'b01: begin
                be_n    = 4'b0011 << {i_addr_M[1], 1'b0};
                wdata_n = {2{i_wdata_M[15:0]}};
            end
            default: begin
                be_n    = 4'b1111;
                wdata_n = i_wdata_M;
            end
        endcase
    end

    // Shift the returned word down to the accessed lane and extend it
    always_comb begin
        shifted = bus.i_bus_rdata >> {off_q, 3'b000};
        unique case (f3_q)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ext = {24'd0, shifted[7:0]};
            3'b101:  ext = {16'd0, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Access sequencer: next state, latched fields, stall and pulses
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = '0;
        mis_d   = 1'b0;
        err_d   = 1'b0;
        stall   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_req_M && legal) begin
                    stall   = 1'b1;
                    we_d    = i_we_M;
                    f3_d    = i_funct3_M;
                    off_d   = i_addr_M[1:0];
                    addr_d  = {i_addr_M[DATA_WIDTH-1:2], 2'b00};
                    be_d    = be_n;
                    wdata_d = wdata_n;
                    state_d = S_REQ;
                end else if (i_req_M) begin
                    mis_d = 1'b1;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (tmo) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else if (bus.i_bus_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (bus.i_bus_rvalid) begin
                    if (!we_q) begin
                        rdata_d = ext;
                    end
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    assign req             = (state_q == S_REQ);
    assign o_read_data_M   = rdata_q;
    assign o_misaligned_M  = mis_q;
    assign o_bus_err       = err_q;
    assign o_stall_M       = stall & ~rst;
    assign bus.o_bus_req   = req;
    assign bus.o_bus_we    = req & we_q;
    assign bus.o_bus_addr  = addr_q;
    assign bus.o_bus_be    = be_q;
    assign bus.o_bus_wdata = wdata_q;
endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if with a transaction-level model
// and a per-cycle compare process.
module tb_lsu_mem_if;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_M;
    logic        i_we_M;
    logic [2:0]  i_funct3_M;
    logic [31:0] i_addr_M;
    logic [31:0] i_wdata_M;
    logic [31:0] o_read_data_M;
    logic        o_stall_M;
    logic        o_misaligned_M;
    logic        o_bus_err;

    lsu_mem_if_if bif ();

    lsu_mem_if #(
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req_M        (i_req_M),
        .i_we_M         (i_we_M),
        .i_funct3_M     (i_funct3_M),
        .i_addr_M       (i_addr_M),
        .i_wdata_M      (i_wdata_M),
        .o_read_data_M  (o_read_data_M),
        .o_stall_M      (o_stall_M),
        .o_misaligned_M (o_misaligned_M),
        .o_bus_err      (o_bus_err),
        .bus            (bif)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    bit          chk_en = 1'b0;
    bit          exp_stall, exp_req, exp_we, exp_mis, exp_err;
    logic [31:0] exp_addr, exp_wdata, exp_rd;
    logic [3:0]  exp_be;
    logic [31:0] cur_rd;
    logic [3:0]  last_be;
    logic [31:0] last_wdata;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: legality of a MEM request
    function automatic bit legal_m(input bit we, input logic [2:0] f3,
                                   input logic [31:0] a);
        case (f3)
            3'b000:  return 1'b1;
            3'b001:  return (a % 2) == 0;
            3'b010:  return (a % 4) == 0;
            3'b100:  return !we;
            3'b101:  return !we && (a % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] be_m(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] wd_m(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
        if (f3[1:0] == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ld_m(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] w);
        longint v;
        v = longint'(w) >> (8 * (a % 4));
        case (f3)
            3'b000: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            3'b001: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            3'b100: v = v % 256;
            3'b101: v = v % 65536;
            default: v = v % 64'h1_0000_0000;
        endcase
        return v[31:0];
    endfunction

    // Compare DUT outputs against the model expectations each cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 32'(o_stall_M), 32'(exp_stall));
            check("bus_req", 32'(bif.o_bus_req), 32'(exp_req));
            check("bus_we", 32'(bif.o_bus_we), 32'(exp_we));
            check("misaligned", 32'(o_misaligned_M), 32'(exp_mis));
            check("bus_err", 32'(o_bus_err), 32'(exp_err));
            check("read_data", o_read_data_M, exp_rd);
            if (exp_req) begin
                check("bus_addr", bif.o_bus_addr, exp_addr);
                check("bus_be", 32'(bif.o_bus_be), 32'(exp_be));
                check("bus_wdata", bif.o_bus_wdata, exp_wdata);
                last_be    = bif.o_bus_be;
                last_wdata = bif.o_bus_wdata;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        exp_stall = 0; exp_req = 0; exp_we = 0;
        exp_mis = 0; exp_err = 0; exp_rd = cur_rd;
    endtask

    // gd: cycles gnt is withheld (-1 = never); rd: cycles from gnt to rvalid
    task automatic access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int gd, input int rd,
                          input logic [31:0] rw);
        bit lg;
        bit abort;
        bit g;
        bit v;
        int c;
        lg = legal_m(we, f3, a);
        i_req_M = 1; i_we_M = we; i_funct3_M = f3; i_addr_M = a; i_wdata_M = wd;
        idle_exp();
        exp_stall = lg;
        exp_addr  = a & 32'hFFFF_FFFC;
        exp_be    = be_m(f3, a);
        exp_wdata = wd_m(f3, wd);
        step();
        if (!lg) begin
            i_req_M = 0;
            exp_mis = 1;
            step();
            exp_mis = 0;
            step();
            return;
        end
        c = 0;
        abort = 0;
        forever begin
            c++;
            g = (gd >= 0) && (c == gd + 1);
            bif.i_bus_gnt = g;
            exp_req = 1; exp_we = we; exp_stall = 1;
            step();
            if (c == TMO) begin abort = 1; break; end
            if (g) break;
        end
        bif.i_bus_gnt = 0;
        exp_req = 0; exp_we = 0;
        if (!abort) begin
            for (int k = 1; ; k++) begin
                c++;
                v = (k == rd);
                bif.i_bus_rvalid = v;
                bif.i_bus_rdata  = v ? rw : 32'hA5A5_5A5A;
                step();
                if (v) break;
                if (c == TMO) begin abort = 1; break; end
            end
        end
        bif.i_bus_rvalid = 0;
        bif.i_bus_rdata  = 32'hA5A5_5A5A;
        if (abort) cur_rd = 32'h0;
        else if (!we) cur_rd = ld_m(f3, a, rw);
        exp_stall = 0;
        exp_err   = abort;
        exp_rd    = cur_rd;
        step();
        i_req_M = 0;
        idle_exp();
        step();
    endtask

    initial begin
        rst = 1;
        i_req_M = 0; i_we_M = 0; i_funct3_M = 3'b000;
        i_addr_M = 0; i_wdata_M = 0;
        bif.i_bus_gnt = 0; bif.i_bus_rvalid = 0; bif.i_bus_rdata = 0;
        cur_rd = 0;
        idle_exp();
        exp_addr = 0; exp_be = 0; exp_wdata = 0;
        #3;
        check("rst_stall", 32'(o_stall_M), 32'd0);
        check("rst_req", 32'(bif.o_bus_req), 32'd0);
        check("rst_be", 32'(bif.o_bus_be), 32'd0);
        check("rst_addr", bif.o_bus_addr, 32'd0);
        check("rst_rdata", o_read_data_M, 32'd0);
        step();
        step();
        rst = 0;
        chk_en = 1;

        access(0, 3'b010, 32'h100, 32'h0, 0, 1, 32'hDEAD_BEEF);
        check("lw_data_lit", o_read_data_M, 32'hDEAD_BEEF);
        check("lw_be_lit", 32'(last_be), 32'h0000_000F);

        access(0, 3'b000, 32'h103, 32'h0, 0, 1, 32'h80FF_FFFF);
        check("lb_data_lit", o_read_data_M, 32'hFFFF_FF80);
        check("lb_be_lit", 32'(last_be), 32'h0000_0008);

        access(0, 3'b100, 32'h103, 32'h0, 0, 1, 32'h80FF_FFFF);
        check("lbu_data_lit", o_read_data_M, 32'h0000_0080);

        access(1, 3'b001, 32'h202, 32'h1234_ABCD, 0, 1, 32'h0);
        check("sh_wdata_lit", last_wdata, 32'hABCD_ABCD);
        check("sh_be_lit", 32'(last_be), 32'h0000_000C);
        check("sh_keeps_rd", o_read_data_M, 32'h0000_0080);

        access(0, 3'b010, 32'h101, 32'h0, 0, 1, 32'h0);
        access(1, 3'b101, 32'h204, 32'h0, 0, 1, 32'h0);
        access(0, 3'b011, 32'h208, 32'h0, 0, 1, 32'h0);
        access(0, 3'b001, 32'h205, 32'h0, 0, 1, 32'h0);

        access(0, 3'b010, 32'h300, 32'h0, 5, 2, 32'h0BAD_F00D);
        access(0, 3'b001, 32'h302, 32'h0, 1, 1, 32'h9ABC_1234);
        check("lh_data_lit", o_read_data_M, 32'hFFFF_9ABC);
        access(0, 3'b101, 32'h302, 32'h0, 0, 3, 32'h9ABC_1234);
        access(1, 3'b000, 32'h001, 32'h0000_0077, 2, 1, 32'h0);
        check("sb_wdata_lit", last_wdata, 32'h7777_7777);
        access(1, 3'b010, 32'h010, 32'hCAFE_0001, 0, 2, 32'h0);
        access(0, 3'b000, 32'h002, 32'h0, 0, 1, 32'h0055_0000);

        access(0, 3'b010, 32'h500, 32'h0, -1, 1, 32'h0);
        check("tmo_rd_lit", o_read_data_M, 32'h0);
        access(0, 3'b010, 32'h504, 32'h0, 0, 1, 32'h1122_3344);

        chk_en = 0;
        i_req_M = 1; i_we_M = 1; i_funct3_M = 3'b010;
        i_addr_M = 32'h400; i_wdata_M = 32'hFFFF_FFFF;
        step();
        bif.i_bus_gnt = 1;
        step();
        bif.i_bus_gnt = 0;
        check("pre_rst_stall", 32'(o_stall_M), 32'd1);
        #2 rst = 1;
        #1;
        check("mid_rst_stall", 32'(o_stall_M), 32'd0);
        check("mid_rst_req", 32'(bif.o_bus_req), 32'd0);
        check("mid_rst_we", 32'(bif.o_bus_we), 32'd0);
        check("mid_rst_addr", bif.o_bus_addr, 32'd0);
        check("mid_rst_be", 32'(bif.o_bus_be), 32'd0);
        check("mid_rst_wdata", bif.o_bus_wdata, 32'd0);
        check("mid_rst_rdata", o_read_data_M, 32'd0);
        check("mid_rst_err", 32'(o_bus_err), 32'd0);
        step();
        rst = 0;
        i_req_M = 0;
        bif.i_bus_rvalid = 1;
        bif.i_bus_rdata  = 32'h7654_3210;
        step();
        bif.i_bus_rvalid = 0;
        check("post_rst_stall", 32'(o_stall_M), 32'd0);
        check("post_rst_rdata", o_read_data_M, 32'd0);
        check("post_rst_req", 32'(bif.o_bus_req), 32'd0);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store unit between the pipeline's MEM stage and the data bus.
- Consumes the MEM-stage address, store data, write strobe and funct3.
- Drives a req/gnt/rvalid data bus with byte enables.
- Returns aligned, sign- or zero-extended load data to the MEM/WB register.
- Holds the pipeline with a stall while an access is outstanding.

Parameters:
DATA_WIDTH, 32, data/address width; only 32 is supported (4 byte lanes).
TIMEOUT_CYCLES, 255, maximum cycles spent in REQ+WAIT before the access is aborted with o_bus_err.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
i_req_M  in  1  valid load/store in MEM this cycle
i_we_M  in  1  1=store, 0=load
i_funct3_M  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
i_addr_M  in  32  byte address (ALU result)
i_wdata_M  in  32  store data (rs2, forwarded)
o_read_data_M  out  32  extended load data to MEM/WB
o_stall_M  out  1  freeze IF/ID/EX/MEM while high
o_misaligned_M  out  1  one-cycle pulse: misaligned access or illegal funct3
o_bus_err  out  1  one-cycle pulse: timeout abort
o_bus_req  out  1  bus request
o_bus_we  out  1  bus write
o_bus_addr  out  32  word address, {addr[31:2],2'b00}
o_bus_be  out  4  byte enables
o_bus_wdata  out  32  lane-replicated store data
i_bus_gnt  in  1  request accepted
i_bus_rvalid  in  1  response (load data or store ack)
i_bus_rdata  in  32  load data word

Behaviour:
- Reset (async): state=IDLE.
  - o_bus_req, o_bus_we, o_stall_M, o_misaligned_M, o_bus_err = 0.
  - o_bus_addr, o_bus_be, o_bus_wdata, o_read_data_M = 0.
  - Timeout counter = 0.
- Alignment check:
  - h/hu needs addr[0]=0; w needs addr[1:0]=00; b is always aligned.
  - funct3 011/110/111 is illegal.
  - bu/hu with i_we_M=1 is illegal.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - i_req_M=1 and legal: latch we/funct3/addr[1:0]; register bus fields; go to REQ. o_stall_M=1 combinationally this cycle.
  - i_req_M=1 and illegal: o_misaligned_M=1 next cycle (registered); no bus access; no stall; o_read_data_M unchanged; state stays IDLE.
- REQ:
  - o_bus_req=1; all bus fields held stable.
  - i_bus_gnt=1: drop req next cycle, go to WAIT.
  - o_stall_M=1.
- WAIT:
  - o_stall_M=1.
  - i_bus_rvalid=1: on a load, capture the extended data into o_read_data_M; go to DONE.
  - rvalid is ignored in IDLE/REQ; the bus must give rvalid at the earliest one cycle after gnt.
- DONE:
  - o_stall_M=0 for exactly one cycle so the pipeline advances; go to IDLE.
  - o_read_data_M holds until the next load completes.
- Timeout counter:
  - Counts every cycle in REQ or WAIT; cleared in IDLE.
  - Reaching TIMEOUT_CYCLES: deassert req, o_bus_err pulse, o_read_data_M=0, go to DONE.
- Byte enables:
  - sb: 4'b0001<<addr[1:0].
  - sh: 4'b0011<<{addr[1],1'b0}.
  - sw: 4'b1111.
  - Loads drive the same be pattern.
- Store data:
  - sb: {4{wdata[7:0]}}.
  - sh: {2{wdata[15:0]}}.
  - sw: wdata.
- Load extraction:
  - Shift i_bus_rdata right by 8*addr[1:0] (h uses addr[1]).
  - lb/lh: sign-extend; lbu/lhu: zero-extend; lw: unchanged.
- Minimum stall: 3 cycles (IDLE-detect, REQ with gnt, WAIT with rvalid), then the DONE cycle releases.
- Reset mid-access: immediate return to IDLE; any outstanding response is dropped.

Test Plan:
- lw addr=0x100, gnt same cycle, rdata=0xDEADBEEF one cycle later -> o_bus_be=1111, stall high 3 cycles, o_read_data_M=0xDEADBEEF on release.
- lb addr=0x103 with rdata=0x80FFFFFF -> be=1000, data=0xFFFFFF80; lbu same access -> data=0x00000080.
- sh addr=0x202 with wdata=0x1234ABCD -> o_bus_we=1, be=1100, o_bus_wdata=0xABCDABCD; stall released after ack.
- lw addr=0x101 -> o_misaligned_M pulses 1 cycle, o_bus_req never asserts, o_stall_M stays 0.
- gnt withheld for 5 cycles -> req and all bus fields stable throughout, stall held; completion follows gnt and rvalid normally.
- TIMEOUT_CYCLES=8 with gnt never given -> o_bus_err pulse after 8 REQ cycles, o_read_data_M=0, stall releases; rst asserted in WAIT -> all outputs zero immediately.
